// File: rtl/otter_pkg.sv
// Shared OTTER definitions: register index width, write-back
// arbitration priority state and the registered write bundle.
package otter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << REG_W;

    typedef enum logic {
        PRI_LD = 1'b0,
        PRI_EX = 1'b1
    } pri_t;

    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, x0 never busy.
// Set wins over clear when both hit the same bit at one edge.
module regfile_scoreboard
    import otter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_W-1:0]  set_idx,
    input  logic              clr_en,
    input  logic [REG_W-1:0]  clr_idx,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic              rd_valid,
    input  logic [REG_W-1:0]  rd,
    output logic [NREGS-1:0]  busy,
    output logic              hazard
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign hazard = busy_q[rs1] | busy_q[rs2] | (rd_valid & busy_q[rd]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter between execute and load ports,
// with a registered register-file write and an issue scoreboard.
module regfile_wb_arbiter
    import otter_pkg::*;
#(
    parameter bit INIT_PRI_LD = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    output logic              stall,
    input  logic              ex_valid,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    output logic              ex_ready,
    input  logic              ld_valid,
    input  logic [REG_W-1:0]  ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREGS-1:0]  busy
);

    localparam pri_t PRI_INIT = INIT_PRI_LD ? PRI_LD : PRI_EX;

    pri_t   pri_q;
    rf_wr_t wr_q;
    logic   ex_fire;
    logic   ld_fire;
    logic   issue_fire;
    logic   hazard;

    always_comb begin
        ex_ready = 1'b0;
        ld_ready = 1'b0;
        if (!reset) begin
            ex_ready = ex_valid & (!ld_valid | (pri_q == PRI_EX));
            ld_ready = ld_valid & (!ex_valid | (pri_q == PRI_LD));
        end
    end

    assign ex_fire    = ex_valid & ex_ready;
    assign ld_fire    = ld_valid & ld_ready;
    assign stall      = hazard;
    assign issue_fire = issue_valid & ~hazard & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            pri_q <= PRI_INIT;
            wr_q  <= '0;
        end else begin
            if (ex_fire) begin
                pri_q <= PRI_LD;
                wr_q  <= '{we: (ex_rd != '0), addr: ex_rd, data: ex_data};
            end else if (ld_fire) begin
                pri_q <= PRI_EX;
                wr_q  <= '{we: (ld_rd != '0), addr: ld_rd, data: ld_data};
            end else begin
                wr_q  <= '0;
            end
        end
    end

    assign rf_we    = wr_q.we;
    assign rf_waddr = wr_q.addr;
    assign rf_wdata = wr_q.data;

    regfile_scoreboard u_sb (
        .clock    (clock),
        .reset    (reset),
        .set_en   (issue_fire),
        .set_idx  (issue_rd),
        .clr_en   (wr_q.we),
        .clr_idx  (wr_q.addr),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd_valid (issue_valid),
        .rd       (issue_rd),
        .busy     (busy),
        .hazard   (hazard)
    );

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter INIT_PRI_LD, default 1, meaning: load port holds priority after reset (0 = execute port).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports issue_valid input 1 / issue_rd input 5: instruction issue with destination register.
REQ-005 SHALL have ports rs1 input 5 / rs2 input 5: source registers of the issuing instruction.
REQ-006 SHALL have port stall  output  1  hazard on rs1, rs2 or issue_rd; issue must wait.
REQ-007 SHALL have ports ex_valid input 1, ex_rd input 5, ex_data input 32, ex_ready output 1: execute write-back requester.
REQ-008 SHALL have ports ld_valid input 1, ld_rd input 5, ld_data input 32, ld_ready output 1: load write-back requester.
REQ-009 SHALL have ports rf_we output 1, rf_waddr output 5, rf_wdata output 32: register-file write port.
REQ-010 SHALL have port busy  output  32  scoreboard; bit n set = write to xn pending.

Function
REQ-011 Transfer occurs on a requester when valid and ready are both high at a rising edge.
REQ-012 At most one of ex_ready, ld_ready SHALL be high per cycle; each is combinational from valid inputs and priority state.
REQ-013 Single request: the requesting port SHALL get ready=1 in the same cycle.
REQ-014 Both requesting: the port holding priority SHALL get ready; the other SHALL see ready=0 and hold valid, rd, data stable until granted.
REQ-015 Priority state SHALL be two states, PRI_LD and PRI_EX; after a grant, priority moves to the other port (round-robin); without a grant, it holds.
REQ-016 A transfer in cycle N SHALL produce rf_we=1, rf_waddr=rd, rf_wdata=data in cycle N+1 (registered; latency 1).
REQ-017 A transfer with rd=0 SHALL be accepted (ready=1) but SHALL leave rf_we=0 in cycle N+1.
REQ-018 No transfer in cycle N SHALL give rf_we=0 in cycle N+1; rf_waddr and rf_wdata SHALL then be 0.
REQ-019 Issue accepted when issue_valid=1 and stall=0; issue_valid during stall SHALL be ignored (no scoreboard change).
REQ-020 An accepted issue with issue_rd != 0 SHALL set busy[issue_rd] at that edge.
REQ-021 busy[n] SHALL clear at the edge ending the cycle in which rf_we=1 and rf_waddr=n.
REQ-022 Set and clear of the same bit at the same edge: set SHALL win.
REQ-023 busy[0] SHALL be constant 0.
REQ-024 stall SHALL equal busy[rs1] | busy[rs2] | (issue_valid & busy[issue_rd]), combinational; no write-back bypass.
REQ-025 A transfer to a register whose busy bit is clear SHALL still be written; the scoreboard SHALL be unchanged.

Reset
REQ-026 reset=1 at an edge SHALL force busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, priority=PRI_LD if INIT_PRI_LD=1 else PRI_EX.
REQ-027 While reset=1, ex_ready and ld_ready SHALL be 0 and no transfer or issue SHALL be accepted.
REQ-028 Reset asserted mid-operation SHALL discard the pending registered write; no rf_we in the cycle after reset.

Structure
REQ-029 Priority-state enum and register-index width (5) SHALL live in the shared OTTER package.
REQ-030 Scoreboard SHALL be a sub-module regfile_scoreboard (set, clear, busy, hazard query); arbitration and write register stay in the top.

Verification
REQ-031 Reset, then ex_valid=1, ex_rd=5, ex_data=0xDEADBEEF -> ex_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-032 Both valid for 3 consecutive transfers (INIT_PRI_LD=1) -> grant order ld, ex, ld; held port's data unchanged until granted.
REQ-033 Issue rd=7; next cycle rs1=7 -> stall=1; write-back to x7 -> busy[7] clears after the rf_we cycle, then stall=0.
REQ-034 Write-back to x3 on rf_we in the same cycle as a new issue with rd=3 -> busy[3] remains 1.
REQ-035 ld transfer with ld_rd=0, data 0x1234 -> ld_ready=1, rf_we stays 0; issue rd=0 -> busy stays 0.
REQ-036 Reset asserted the cycle after an ex transfer to x9 with busy[9]=1 -> rf_we=0, busy=0, readies 0 while reset high.
